// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer: access sizes, funct3 field
// widths, FSM states and the byte-mask helper used for overlap compares.
package store_buffer_pkg;

  localparam int FUNCT3_BITS   = 3;
  localparam int SIZE_BITS     = 2;
  localparam int LINE_OFS_BITS = 3;
  localparam int MASK_BITS     = 16;

  typedef enum logic [SIZE_BITS-1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } access_size_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FENCE = 1'b1
  } sb_state_t;

  // Byte mask over two consecutive dword lines: bits [7:0] cover the line the
  // access starts in, bits [15:8] the following line (for misaligned spills).
  function automatic logic [MASK_BITS-1:0] byte_mask(input access_size_t size,
                                                     input logic [LINE_OFS_BITS-1:0] ofs);
    logic [MASK_BITS-1:0] base;
    case (size)
      SZ_B:    base = 16'h0001;
      SZ_H:    base = 16'h0003;
      SZ_W:    base = 16'h000F;
      default: base = 16'h00FF;
    endcase
    return base << ofs;
  endfunction

endpackage

// File: rtl/sb_overlap.sv
// Combinational byte-overlap compare of one buffered store against the
// current load. Each access covers its start line and the next line (wrapping
// modulo the line-index range); overlap means a shared line with common bytes.
module sb_overlap
  import store_buffer_pkg::*;
#(
  parameter int ADDR_BITS = 16
) (
  input  logic                 entry_valid,
  input  logic [ADDR_BITS-1:0] entry_addr,
  input  access_size_t         entry_size,
  input  logic [ADDR_BITS-1:0] ld_addr,
  input  access_size_t         ld_size,
  output logic                 overlap,
  output logic                 exact
);

  localparam int LINE_BITS = ADDR_BITS - LINE_OFS_BITS;

  logic [LINE_BITS-1:0] e_line0, e_line1, l_line0, l_line1;
  logic [MASK_BITS-1:0] e_mask, l_mask;
  logic                 hit_00, hit_01, hit_10, hit_11;

  assign e_line0 = entry_addr[ADDR_BITS-1:LINE_OFS_BITS];
  assign l_line0 = ld_addr[ADDR_BITS-1:LINE_OFS_BITS];
  assign e_line1 = e_line0 + LINE_BITS'(1);
  assign l_line1 = l_line0 + LINE_BITS'(1);
  assign e_mask  = byte_mask(entry_size, entry_addr[LINE_OFS_BITS-1:0]);
  assign l_mask  = byte_mask(ld_size, ld_addr[LINE_OFS_BITS-1:0]);

  // Pairwise line match with intersecting byte lanes.
  always_comb begin
    hit_00  = (e_line0 == l_line0) && (|(e_mask[7:0]  & l_mask[7:0]));
    hit_01  = (e_line0 == l_line1) && (|(e_mask[7:0]  & l_mask[15:8]));
    hit_10  = (e_line1 == l_line0) && (|(e_mask[15:8] & l_mask[7:0]));
    hit_11  = (e_line1 == l_line1) && (|(e_mask[15:8] & l_mask[15:8]));
    overlap = entry_valid && (hit_00 || hit_01 || hit_10 || hit_11);
    exact   = entry_valid && (entry_addr == ld_addr) && (entry_size == ld_size);
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data memory. Stores are queued and
// drained in order whenever the memory port is not taken by a load; loads that
// overlap a buffered store are stalled until the conflicting stores drain.
// A fence empties the buffer and acknowledges with a one-cycle pulse.
// Optional feature macro: STORE_BUF_FWD_EN (exact-match store-to-load forwarding).
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_BITS = 16,
  parameter int BUS_BITS  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [BUS_BITS-1:0]    st_addr,
  input  logic [FUNCT3_BITS-1:0] st_funct3,
  input  logic [BUS_BITS-1:0]    st_data,
  input  logic                   ld_valid,
  input  logic [BUS_BITS-1:0]    ld_addr,
  input  logic [FUNCT3_BITS-1:0] ld_funct3,
  output logic                   ld_stall,
  input  logic                   fence_req,
  output logic                   fence_ack,
  output logic                   mem_we,
  output logic [BUS_BITS-1:0]    mem_addr,
  output logic [FUNCT3_BITS-1:0] mem_funct3,
  output logic [BUS_BITS-1:0]    mem_store_data,
  output logic                   ld_fwd_hit,
  output logic [BUS_BITS-1:0]    ld_fwd_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [ADDR_BITS-1:0] ent_addr [DEPTH];
  access_size_t         ent_size [DEPTH];
  logic [BUS_BITS-1:0]  ent_data [DEPTH];
  logic [DEPTH-1:0]     ent_valid;

  logic [PTR_W-1:0] head, tail;
  logic [IDX_W-1:0] head_idx, tail_idx;
  sb_state_t        state;

  logic             full, empty, push, pop, ld_go, any_ovl, fwd_match;
  logic [DEPTH-1:0] ovl, exact;
  access_size_t     ld_size;

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];
  assign full     = (head[PTR_W-1] != tail[PTR_W-1]) && (head_idx == tail_idx);
  assign empty    = (head == tail);
  assign st_ready = !full && (state == ST_RUN);
  assign push     = st_valid && st_ready;
  assign ld_size  = access_size_t'(ld_funct3[1:0]);

  for (genvar g = 0; g < DEPTH; g++) begin : g_ovl
    sb_overlap #(.ADDR_BITS(ADDR_BITS)) u_ovl (
      .entry_valid (ent_valid[g]),
      .entry_addr  (ent_addr[g]),
      .entry_size  (ent_size[g]),
      .ld_addr     (ld_addr[ADDR_BITS-1:0]),
      .ld_size     (ld_size),
      .overlap     (ovl[g]),
      .exact       (exact[g])
    );
  end

  assign any_ovl = |ovl;

`ifdef STORE_BUF_FWD_EN
  logic [IDX_W-1:0] fwd_sel;
  logic [IDX_W-1:0] slot;

  // Walk from oldest to youngest; the last overlapping entry decides whether
  // the load can be satisfied by forwarding.
  always_comb begin
    fwd_match = 1'b0;
    fwd_sel   = '0;
    slot      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_idx + IDX_W'(k);
      if (ovl[slot]) begin
        fwd_match = exact[slot];
        fwd_sel   = slot;
      end
    end
  end

  function automatic logic [BUS_BITS-1:0] load_extend(input logic [BUS_BITS-1:0] d,
                                                      input access_size_t sz,
                                                      input logic is_unsigned);
    logic [BUS_BITS-1:0] r;
    case (sz)
      SZ_B:    r = is_unsigned ? BUS_BITS'(d[7:0])  : {{(BUS_BITS-8){d[7]}},   d[7:0]};
      SZ_H:    r = is_unsigned ? BUS_BITS'(d[15:0]) : {{(BUS_BITS-16){d[15]}}, d[15:0]};
      SZ_W:    r = is_unsigned ? BUS_BITS'(d[31:0]) : {{(BUS_BITS-32){d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Forwarded data is registered so it lines up with memory load data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_fwd_hit  <= 1'b0;
      ld_fwd_data <= '0;
    end else begin
      ld_fwd_hit  <= ld_valid && fwd_match;
      ld_fwd_data <= (ld_valid && fwd_match)
                     ? load_extend(ent_data[fwd_sel], ld_size, ld_funct3[2]) : '0;
    end
  end
`else
  assign fwd_match   = 1'b0;
  assign ld_fwd_hit  = 1'b0;
  assign ld_fwd_data = '0;

  logic unused_exact;
  assign unused_exact = ^exact;
`endif

  assign ld_stall = ld_valid && any_ovl && !fwd_match;
  assign ld_go    = ld_valid && !ld_stall;
  assign pop      = !ld_go && !empty;

  // Memory port arbitration: an unstalled load wins, else the head store drains.
  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_funct3     = '0;
    mem_store_data = '0;
    if (ld_go) begin
      mem_addr   = ld_addr;
      mem_funct3 = ld_funct3;
    end else if (!empty) begin
      mem_we         = 1'b1;
      mem_addr       = BUS_BITS'(ent_addr[head_idx]);
      mem_funct3     = {1'b0, ent_size[head_idx]};
      mem_store_data = ent_data[head_idx];
    end
  end

  // Pointers and per-slot valid bits; reset discards buffered stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      ent_valid <= '0;
    end else begin
      if (push) begin
        ent_valid[tail_idx] <= 1'b1;
        tail                <= tail + PTR_W'(1);
      end
      if (pop) begin
        ent_valid[head_idx] <= 1'b0;
        head                <= head + PTR_W'(1);
      end
    end
  end

  // Entry payload; contents only matter while the slot is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail_idx] <= st_addr[ADDR_BITS-1:0];
      ent_size[tail_idx] <= access_size_t'(st_funct3[1:0]);
      ent_data[tail_idx] <= st_data;
    end
  end

  // Fence sequencing: stop accepting stores, return to RUN once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (fence_req) state <= ST_FENCE;
        ST_FENCE: if (empty)     state <= ST_RUN;
        default:                 state <= ST_RUN;
      endcase
    end
  end

  assign fence_ack = (state == ST_FENCE) && empty;

  logic unused_bits;
  assign unused_bits = ^{st_addr[BUS_BITS-1:ADDR_BITS], st_funct3[2]};

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: overlap vector table, scoreboard of
// expected memory writes, and hand-written fill/fence/forwarding sequences.
module tb_store_buffer;

`ifdef STORE_BUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid, st_ready;
  logic [63:0] st_addr, st_data;
  logic [2:0]  st_funct3;
  logic        ld_valid, ld_stall;
  logic [63:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic        fence_req, fence_ack;
  logic        mem_we;
  logic [63:0] mem_addr, mem_store_data;
  logic [2:0]  mem_funct3;
  logic        ld_fwd_hit;
  logic [63:0] ld_fwd_data;

  store_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_funct3(st_funct3), .st_data(st_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3), .ld_stall(ld_stall),
    .fence_req(fence_req), .fence_ack(fence_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_funct3(mem_funct3),
    .mem_store_data(mem_store_data),
    .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  f3;
    logic [63:0] data;
  } wr_t;

  typedef struct {
    logic [63:0] st_addr;
    logic [2:0]  st_f3;
    logic [63:0] ld_addr;
    logic [2:0]  ld_f3;
    logic        exp_stall;
    logic        exp_fwd;
  } vec_t;

  wr_t  sb_q[$];
  wr_t  mon_w;
  vec_t vecs[9];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_push(input logic [63:0] a, input logic [2:0] f3, input logic [63:0] d);
    wr_t w;
    w.addr = {48'h0, a[15:0]};
    w.f3   = {1'b0, f3[1:0]};
    w.data = d;
    sb_q.push_back(w);
  endtask

  task automatic wait_empty(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && mem_we === 1'b0) done = 1'b1;
      next_cycle();
    end
    chk(name, 64'(done), 64'd1);
  endtask

  // Scoreboard: every memory write must match the oldest expected store.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_write actual addr=0x%0h required no write", mem_addr);
      end else begin
        mon_w = sb_q.pop_front();
        chk("sb_addr", mem_addr, mon_w.addr);
        chk("sb_funct3", 64'(mem_funct3), 64'(mon_w.f3));
        chk("sb_data", mem_store_data, mon_w.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acks;
    int ack_cycle;

    vecs[0] = '{64'h104,   3'd2, 64'h106,  3'd0, 1'b1, 1'b0};
    vecs[1] = '{64'hFFFF,  3'd1, 64'h0000, 3'd0, 1'b1, 1'b0};
    vecs[2] = '{64'h107,   3'd0, 64'h108,  3'd4, 1'b0, 1'b0};
    vecs[3] = '{64'h100,   3'd3, 64'h104,  3'd2, 1'b1, 1'b0};
    vecs[4] = '{64'h0FE,   3'd2, 64'h101,  3'd0, 1'b1, 1'b0};
    vecs[5] = '{64'h0FE,   3'd2, 64'h102,  3'd5, 1'b0, 1'b0};
    vecs[6] = '{64'h200,   3'd1, 64'h200,  3'd1, !FWD, FWD};
    vecs[7] = '{64'h010,   3'd0, 64'h018,  3'd3, 1'b0, 1'b0};
    vecs[8] = '{64'h10000, 3'd0, 64'h0000, 3'd1, 1'b1, 1'b0};

    st_valid = 0; st_addr = 0; st_funct3 = 0; st_data = 0;
    ld_valid = 0; ld_addr = 0; ld_funct3 = 0; fence_req = 0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_ld_stall", 64'(ld_stall), 64'd0);
    chk("rst_fence_ack", 64'(fence_ack), 64'd0);
    chk("rst_fwd_hit", 64'(ld_fwd_hit), 64'd0);
    chk("rst_fwd_data", ld_fwd_data, 64'd0);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    next_cycle();

    // single SD, drains the following cycle
    st_valid = 1; st_addr = 64'h100; st_funct3 = 3'd3; st_data = 64'h1122334455667788;
    @(negedge clk);
    chk("sd_st_ready", 64'(st_ready), 64'd1);
    chk("sd_no_same_cycle_drain", 64'(mem_we), 64'd0);
    expect_push(st_addr, st_funct3, st_data);
    next_cycle();
    st_valid = 0;
    @(negedge clk);
    chk("sd_mem_we", 64'(mem_we), 64'd1);
    chk("sd_mem_addr", mem_addr, 64'h100);
    chk("sd_mem_funct3", 64'(mem_funct3), 64'd3);
    next_cycle();
    @(negedge clk);
    chk("sd_empty_after", 64'(mem_we), 64'd0);
    next_cycle();

    // fill to full while a non-overlapping load holds the port
    for (int i = 0; i < 5; i++) begin
      st_valid = 1; st_addr = 64'h300 + 64'(8 * i); st_funct3 = 3'd3; st_data = 64'h1000 + 64'(i);
      ld_valid = 1; ld_addr = 64'h200; ld_funct3 = 3'd3;
      @(negedge clk);
      chk($sformatf("fill%0d_st_ready", i), 64'(st_ready), (i < 4) ? 64'd1 : 64'd0);
      if (i < 4) expect_push(st_addr, st_funct3, st_data);
      chk($sformatf("fill%0d_mem_we", i), 64'(mem_we), 64'd0);
      chk($sformatf("fill%0d_ld_pass", i), mem_addr, 64'h200);
      chk($sformatf("fill%0d_ld_stall", i), 64'(ld_stall), 64'd0);
      next_cycle();
    end
    st_valid = 0; ld_valid = 0;
    @(negedge clk);
    chk("fill_drain_start", 64'(mem_we), 64'd1);
    next_cycle();
    wait_empty("fill_drain");

    // overlap vector table
    for (int i = 0; i < 9; i++) begin
      st_valid = 1; st_addr = vecs[i].st_addr; st_funct3 = vecs[i].st_f3;
      st_data = 64'hA5A5_0000_0000_8000 | 64'(i);
      @(negedge clk);
      chk($sformatf("vec%0d_st_ready", i), 64'(st_ready), 64'd1);
      expect_push(st_addr, st_funct3, st_data);
      next_cycle();
      st_valid = 0;
      ld_valid = 1; ld_addr = vecs[i].ld_addr; ld_funct3 = vecs[i].ld_f3;
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 64'(ld_stall), 64'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_mem_we", i), 64'(mem_we), 64'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_mem_addr", i), mem_addr,
          vecs[i].exp_stall ? {48'h0, vecs[i].st_addr[15:0]} : vecs[i].ld_addr);
      next_cycle();
      @(negedge clk);
      chk($sformatf("vec%0d_release", i), 64'(ld_stall), 64'd0);
      chk($sformatf("vec%0d_ld_pass", i), mem_addr, vecs[i].ld_addr);
      chk($sformatf("vec%0d_fwd_hit", i), 64'(ld_fwd_hit), 64'(vecs[i].exp_fwd));
      next_cycle();
      ld_valid = 0;
      wait_empty($sformatf("vec%0d_drain", i));
    end

    // fence with three buffered stores
    for (int i = 0; i < 3; i++) begin
      st_valid = 1; st_addr = 64'h400 + 64'(8 * i); st_funct3 = 3'd3; st_data = 64'hF00D + 64'(i);
      ld_valid = 1; ld_addr = 64'h200; ld_funct3 = 3'd3;
      @(negedge clk);
      chk($sformatf("fence_fill%0d_st_ready", i), 64'(st_ready), 64'd1);
      expect_push(st_addr, st_funct3, st_data);
      next_cycle();
    end
    st_valid = 0; fence_req = 1;
    @(negedge clk);
    chk("fence_ack_early", 64'(fence_ack), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("fence_st_ready", 64'(st_ready), 64'd0);
    chk("fence_load_served", mem_addr, 64'h200);
    chk("fence_load_we", 64'(mem_we), 64'd0);
    next_cycle();
    ld_valid = 0;
    acks = 0;
    ack_cycle = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (fence_ack === 1'b1) begin
        acks++;
        ack_cycle = c;
        chk("fence_ack_when_empty", 64'(sb_q.size()), 64'd0);
        chk("fence_ack_no_write", 64'(mem_we), 64'd0);
        fence_req = 0;
      end
      next_cycle();
    end
    chk("fence_ack_pulses", 64'(acks), 64'd1);
    chk("fence_ack_cycle", 64'(ack_cycle), 64'd3);
    @(negedge clk);
    chk("fence_st_ready_after", 64'(st_ready), 64'd1);
    next_cycle();

    // fence while already empty: ack on the next cycle
    fence_req = 1;
    @(negedge clk);
    chk("efence_ack_first", 64'(fence_ack), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("efence_ack", 64'(fence_ack), 64'd1);
    chk("efence_st_ready", 64'(st_ready), 64'd0);
    fence_req = 0;
    next_cycle();
    @(negedge clk);
    chk("efence_ack_once", 64'(fence_ack), 64'd0);
    chk("efence_st_ready_after", 64'(st_ready), 64'd1);
    next_cycle();

`ifdef STORE_BUF_FWD_EN
    // exact-match forwarding, signed then unsigned word load
    st_valid = 1; st_addr = 64'h40; st_funct3 = 3'd2; st_data = 64'h80000001;
    @(negedge clk);
    chk("fwd_st_ready", 64'(st_ready), 64'd1);
    expect_push(st_addr, st_funct3, st_data);
    next_cycle();
    st_valid = 0;
    ld_valid = 1; ld_addr = 64'h40; ld_funct3 = 3'b010;
    @(negedge clk);
    chk("fwd_lw_stall", 64'(ld_stall), 64'd0);
    chk("fwd_lw_we", 64'(mem_we), 64'd0);
    next_cycle();
    ld_funct3 = 3'b110;
    @(negedge clk);
    chk("fwd_lw_hit", 64'(ld_fwd_hit), 64'd1);
    chk("fwd_lw_data", ld_fwd_data, 64'hFFFFFFFF80000001);
    chk("fwd_lwu_stall", 64'(ld_stall), 64'd0);
    next_cycle();
    ld_valid = 0;
    @(negedge clk);
    chk("fwd_lwu_hit", 64'(ld_fwd_hit), 64'd1);
    chk("fwd_lwu_data", ld_fwd_data, 64'h0000000080000001);
    next_cycle();
    wait_empty("fwd_drain");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
